seq_run_scanner: RTL and testbench

Sequencing controller for the run-of-equal-bits detector datapath. It accepts a parallel word on a start strobe and feeds it serially, one bit per clock and LSB first, through an embedded one-hot run-detector FSM (run of RUN consecutive 0s or 1s). It counts detector hits and records the index of the first hit. It reports the results with a busy/done handshake, so the detector runs as a self-contained scan engine instead of from a switch and a push-button.

---
 rtl/seq_run_scanner.sv | 157 +++++++++++++++
 tb/tb_seq_run_scanner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_run_scanner.sv
// Serial run-of-equal-bits scan engine: loads a word on start, feeds it LSB
// first through a one-hot run detector and reports hit count and first hit.
module seq_run_scanner #(
    parameter int WIDTH = 16,
    parameter int RUN   = 4,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             z,
    output logic             found,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] first_idx
);

    localparam int NDET = 2 * RUN + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [NDET-1:0]  det_q, det_d, det_step;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             z_q, z_d;
    logic             found_q, found_d;

    logic bit_i;
    logic in_zeros;
    logic in_ones;
    logic hit_i;
    logic last_bit;

    assign bit_i    = shift_q[0];
    assign last_bit = (idx_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            det_q       <= NDET'(1);
            idx_q       <= '0;
            hit_count_q <= '0;
            first_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            z_q         <= 1'b0;
            found_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            det_q       <= det_d;
            idx_q       <= idx_d;
            hit_count_q <= hit_count_d;
            first_idx_q <= first_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            z_q         <= z_d;
            found_q     <= found_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Index 0 is A, 1..RUN are Z1..ZRUN, RUN+1..2*RUN are O1..ORUN.
    always_comb begin
        det_step = '0;
        in_zeros = |det_q[RUN:1];
        in_ones  = |det_q[2*RUN:RUN+1];
        if (!bit_i) begin
            if (in_zeros) begin
                for (int k = 1; k < RUN; k++) begin
                    det_step[k+1] = det_q[k];
                end
                det_step[RUN] = det_step[RUN] | det_q[RUN];
            end else begin
                det_step[1] = 1'b1;
            end
        end else begin
            if (in_ones) begin
                for (int k = RUN + 1; k < 2 * RUN; k++) begin
                    det_step[k+1] = det_q[k];
                end
                det_step[2*RUN] = det_step[2*RUN] | det_q[2*RUN];
            end else begin
                det_step[RUN+1] = 1'b1;
            end
        end
        hit_i = det_step[RUN] | det_step[2*RUN];
    end

    always_comb begin
        shift_d     = shift_q;
        det_d       = det_q;
        idx_d       = idx_q;
        hit_count_d = hit_count_q;
        first_idx_d = first_idx_q;
        z_d         = z_q;
        found_d     = found_q;
        busy_d      = (state_q == SCAN);
        done_d      = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d     = data_in;
                    det_d       = NDET'(1);
                    idx_d       = '0;
                    hit_count_d = '0;
                    first_idx_d = '0;
                    found_d     = 1'b0;
                end
            end
            SCAN: begin
                shift_d = shift_q >> 1;
                det_d   = det_step;
                idx_d   = idx_q + CNT_W'(1);
                z_d     = hit_i;
                if (hit_i) begin
                    hit_count_d = hit_count_q + CNT_W'(1);
                    if (!found_q) begin
                        found_d     = 1'b1;
                        first_idx_d = idx_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign z         = z_q;
    assign found     = found_q;
    assign hit_count = hit_count_q;
    assign first_idx = first_idx_q;

endmodule

// File: tb/tb_seq_run_scanner.sv
// Randomized self-checking bench for seq_run_scanner against a run-length
// reference model.
module tb_seq_run_scanner;

    localparam int W  = 16;
    localparam int R  = 4;
    localparam int CW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  data_in;
    logic          busy;
    logic          done;
    logic          z;
    logic          found;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] first_idx;

    int checks = 0;
    int errors = 0;
    int last_cnt = 0;
    int last_first = 0;

    seq_run_scanner #(.WIDTH(W), .RUN(R), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .z         (z),
        .found     (found),
        .hit_count (hit_count),
        .first_idx (first_idx)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hit at bit i whenever the run of equal bits ending at i is >= R long.
    function automatic void model(input logic [W-1:0] w, output int cnt,
                                  output int first, output logic [W-1:0] zv);
        int run;
        cnt   = 0;
        first = 0;
        run   = 0;
        zv    = '0;
        for (int i = 0; i < W; i++) begin
            if (i > 0 && w[i] == w[i-1]) run++;
            else run = 1;
            if (run >= R) begin
                zv[i] = 1'b1;
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endfunction

    task automatic run_job(input logic [W-1:0] word, input bit inject);
        int cnt, first;
        logic [W-1:0] zv;
        model(word, cnt, first, zv);
        start   = 1'b1;
        data_in = word;
        @(posedge clock); #1;
        start   = 1'b0;
        data_in = W'($urandom);
        check("busy_e0", busy, 0);
        for (int e = 1; e <= W; e++) begin
            if (inject && e == 5) begin
                start   = 1'b1;
                data_in = ~word;
            end
            @(posedge clock); #1;
            start = 1'b0;
            check("busy_scan", busy, 1);
            check("done_scan", done, 0);
            check("z_bit", z, zv[e-1]);
        end
        @(posedge clock); #1;
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("hit_count", hit_count, cnt);
        check("found", found, cnt != 0);
        check("first_idx", first_idx, first);
        last_cnt   = cnt;
        last_first = first;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_hold", hit_count, last_cnt);
            check("idle_first", first_idx, last_first);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_z"}, z, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_cnt"}, hit_count, 0);
        check({tag, "_first"}, first_idx, 0);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b1;
        data_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock); #1;
        check("reset_over_start", busy, 0);

        run_job(16'h0000, 1'b0);
        idle(2);
        run_job(16'hAAAA, 1'b0);
        run_job(16'hF0F0, 1'b0);
        run_job(16'h000F, 1'b0);
        idle(1);
        run_job(16'h3C5A, 1'b1);
        run_job(16'hFFFF, 1'b0);
        idle(1);

        // Abort a scan after edge 8 and make sure no done ever follows.
        start   = 1'b1;
        data_in = 16'hFFFF;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_zero("abort");
        reset      = 1'b1;
        last_cnt   = 0;
        last_first = 0;
        idle(W + 2);
        run_job(16'h0000, 1'b0);

        for (int j = 0; j < 40; j++) begin
            run_job(W'($urandom), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
